// File: rtl/mov_sprite_pkg.sv
// rtl/mov_sprite_pkg.sv - shared constants, records and state enum for the moving-sprite line scanner (option macro: MOV_SPRITE_FLIP_EN)
package mov_sprite_pkg;

  localparam int NUM_ENTRIES_DEFAULT = 8;
  localparam int LINE_SLOTS_DEFAULT  = 4;
  localparam int SPRITE_SIZE         = 16;

  // One attribute table entry; the mirror bit only exists when flipping is built in.
  typedef struct packed {
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic [5:0] sel;
    logic       enable;
`ifdef MOV_SPRITE_FLIP_EN
    logic       flip;
`endif
  } sprite_attr_t;

  // One entry of the per-line sprite list (shadow and active lists share this shape).
  typedef struct packed {
    logic [9:0] xpos;
    logic [5:0] sel;
    logic [3:0] row;
`ifdef MOV_SPRITE_FLIP_EN
    logic       flip;
`endif
  } line_slot_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  // True when pos lies in [origin, origin+SPRITE_SIZE); 11-bit compare so a sprite
  // near the bottom/right edge never wraps back to coordinate 0.
  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] origin);
    logic [10:0] p;
    logic [10:0] o;
    p = {1'b0, pos};
    o = {1'b0, origin};
    return (p >= o) && (p < (o + 11'(SPRITE_SIZE)));
  endfunction

endpackage

// File: rtl/mov_sprite_attr_table.sv
// rtl/mov_sprite_attr_table.sv - sprite attribute register table, one write port and one combinational read port
module mov_sprite_attr_table
  import mov_sprite_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEFAULT,
  parameter int IDX_W       = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_index,
  input  sprite_attr_t     wr_attr,
  input  logic [IDX_W-1:0] rd_index,
  output sprite_attr_t     rd_attr
);

  sprite_attr_t table_q [NUM_ENTRIES];

  // Reset only hides entries; positions and patterns keep whatever they held.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        table_q[i].enable <= 1'b0;
      end
    end else if (wr_en && (32'(wr_index) < NUM_ENTRIES)) begin
      table_q[wr_index] <= wr_attr;
    end
  end

  // Read returns the pre-write value, so a same-cycle write never disturbs the scan.
  always_comb begin
    rd_attr = table_q[rd_index];
  end

endmodule

// File: rtl/mov_sprite_scan.sv
// rtl/mov_sprite_scan.sv - per-line sprite evaluation and pixel request pipeline (option macro: MOV_SPRITE_FLIP_EN)
module mov_sprite_scan
  import mov_sprite_pkg::*;
#(
  parameter int NUM_ENTRIES = NUM_ENTRIES_DEFAULT,
  parameter int LINE_SLOTS  = LINE_SLOTS_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_index,
  input  logic [9:0] wr_xpos,
  input  logic [9:0] wr_ypos,
  input  logic [5:0] wr_sel,
  input  logic       wr_enable,
  input  logic       wr_flip,
  input  logic       line_start,
  input  logic [9:0] line_num,
  input  logic [9:0] hcount,
  input  logic       pixel_valid,
  output logic [5:0] spr_select,
  output logic [3:0] spr_x,
  output logic [3:0] spr_y,
  input  logic [1:0] spr_data,
  input  logic       spr_men,
  output logic [1:0] pix_out,
  output logic       pix_hit,
  output logic       overflow
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(LINE_SLOTS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  scan_state_t      state_q;
  scan_state_t      state_d;
  logic [IDX_W-1:0] scan_idx;
  logic [9:0]       line_q;
  sprite_attr_t     wr_attr;
  sprite_attr_t     scan_attr;
  logic             scan_hit;
  line_slot_t       new_slot;
  line_slot_t       shadow_slot [LINE_SLOTS];
  logic [CNT_W-1:0] shadow_cnt;
  line_slot_t       active_slot [LINE_SLOTS];
  logic [LINE_SLOTS-1:0] active_valid;
  logic             look_hit;
  line_slot_t       look_slot;
  logic [3:0]       look_col;
  logic             req_hit;

`ifndef MOV_SPRITE_FLIP_EN
  logic unused_flip;
  assign unused_flip = wr_flip;
`endif

  // Gather the write-port fields into one table record.
  always_comb begin
    wr_attr        = '0;
    wr_attr.xpos   = wr_xpos;
    wr_attr.ypos   = wr_ypos;
    wr_attr.sel    = wr_sel;
    wr_attr.enable = wr_enable;
`ifdef MOV_SPRITE_FLIP_EN
    wr_attr.flip   = wr_flip;
`endif
  end

  mov_sprite_attr_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_attr_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_attr  (wr_attr),
    .rd_index (scan_idx),
    .rd_attr  (scan_attr)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; line_start restarts the scan from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      SCAN:    if (scan_idx == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (line_start) begin
      state_d = SCAN;
    end
  end

  // Vertical hit test for the entry under the scan counter and its list record.
  always_comb begin
    scan_hit      = scan_attr.enable && in_span(line_q, scan_attr.ypos);
    new_slot      = '0;
    new_slot.xpos = scan_attr.xpos;
    new_slot.sel  = scan_attr.sel;
    new_slot.row  = line_q[3:0] - scan_attr.ypos[3:0];
`ifdef MOV_SPRITE_FLIP_EN
    new_slot.flip = scan_attr.flip;
`endif
  end

  // Scan counter and shadow list build; extra hits are dropped and flagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_idx   <= '0;
      line_q     <= '0;
      shadow_cnt <= '0;
      overflow   <= 1'b0;
    end else if (line_start) begin
      scan_idx   <= '0;
      line_q     <= line_num;
      shadow_cnt <= '0;
      overflow   <= 1'b0;
    end else if (state_q == SCAN) begin
      scan_idx <= scan_idx + IDX_W'(1);
      if (scan_hit) begin
        if (shadow_cnt < CNT_W'(LINE_SLOTS)) begin
          for (int i = 0; i < LINE_SLOTS; i++) begin
            if (CNT_W'(i) == shadow_cnt) begin
              shadow_slot[i] <= new_slot;
            end
          end
          shadow_cnt <= shadow_cnt + CNT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  // Publish the finished shadow list to the active list during DONE only.
  always_ff @(posedge clock) begin
    if (reset) begin
      active_valid <= '0;
    end else if ((state_q == DONE) && !line_start) begin
      for (int i = 0; i < LINE_SLOTS; i++) begin
        active_slot[i]  <= shadow_slot[i];
        active_valid[i] <= (CNT_W'(i) < shadow_cnt);
      end
    end
  end

  // Horizontal lookup: lowest active slot covering hcount wins, even if it turns out transparent.
  always_comb begin
    look_hit  = 1'b0;
    look_slot = '0;
    for (int i = LINE_SLOTS - 1; i >= 0; i--) begin
      if (active_valid[i] && in_span(hcount, active_slot[i].xpos)) begin
        look_hit  = 1'b1;
        look_slot = active_slot[i];
      end
    end
    look_hit = look_hit && pixel_valid;
    look_col = hcount[3:0] - look_slot.xpos[3:0];
`ifdef MOV_SPRITE_FLIP_EN
    if (look_slot.flip) begin
      look_col = 4'd15 - look_col;
    end
`endif
  end

  // Stage 1: memory request; a miss presents all-zero fields with req_hit low.
  always_ff @(posedge clock) begin
    if (reset || !look_hit) begin
      req_hit    <= 1'b0;
      spr_select <= '0;
      spr_x      <= '0;
      spr_y      <= '0;
    end else begin
      req_hit    <= 1'b1;
      spr_select <= look_slot.sel;
      spr_x      <= look_col;
      spr_y      <= look_slot.row;
    end
  end

  // Stage 2: colour 0 and masked memory responses are transparent.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_hit <= 1'b0;
      pix_out <= '0;
    end else if (req_hit && spr_men && (spr_data != 2'd0)) begin
      pix_hit <= 1'b1;
      pix_out <= spr_data;
    end else begin
      pix_hit <= 1'b0;
      pix_out <= '0;
    end
  end

endmodule

// File: tb/tb_mov_sprite_scan.sv
// tb/tb_mov_sprite_scan.sv - directed and randomized self-checking bench for mov_sprite_scan
module tb_mov_sprite_scan;

  localparam int NE = 8;
  localparam int LS = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_index;
  logic [9:0] wr_xpos;
  logic [9:0] wr_ypos;
  logic [5:0] wr_sel;
  logic       wr_enable;
  logic       wr_flip;
  logic       line_start;
  logic [9:0] line_num;
  logic [9:0] hcount;
  logic       pixel_valid;
  logic [5:0] spr_select;
  logic [3:0] spr_x;
  logic [3:0] spr_y;
  logic [1:0] spr_data;
  logic       spr_men;
  logic [1:0] pix_out;
  logic       pix_hit;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: table contents plus the list of entry indices visible on the line.
  int m_x [NE];
  int m_y [NE];
  int m_sel [NE];
  bit m_en [NE];
  bit m_flip [NE];
  int act_e [$];
  int act_row [$];
  bit m_ovf;

  mov_sprite_scan #(.NUM_ENTRIES(NE), .LINE_SLOTS(LS)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .wr_xpos     (wr_xpos),
    .wr_ypos     (wr_ypos),
    .wr_sel      (wr_sel),
    .wr_enable   (wr_enable),
    .wr_flip     (wr_flip),
    .line_start  (line_start),
    .line_num    (line_num),
    .hcount      (hcount),
    .pixel_valid (pixel_valid),
    .spr_select  (spr_select),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_data    (spr_data),
    .spr_men     (spr_men),
    .pix_out     (pix_out),
    .pix_hit     (pix_hit),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_line(input int ln);
    act_e.delete();
    act_row.delete();
    m_ovf = 1'b0;
    for (int e = 0; e < NE; e++) begin
      if (m_en[e] && ln >= m_y[e] && ln < m_y[e] + 16) begin
        if (act_e.size() < LS) begin
          act_e.push_back(e);
          act_row.push_back(ln - m_y[e]);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input int sel, input bit en, input bit fl);
    wr_en = 1'b1; wr_index = 3'(idx); wr_xpos = 10'(x); wr_ypos = 10'(y);
    wr_sel = 6'(sel); wr_enable = en; wr_flip = fl;
    tick();
    wr_en = 1'b0;
    m_x[idx] = x; m_y[idx] = y; m_sel[idx] = sel; m_en[idx] = en; m_flip[idx] = fl;
  endtask

  task automatic do_line(input int ln);
    line_start = 1'b1; line_num = 10'(ln);
    tick();
    line_start = 1'b0;
    repeat (NE + 3) tick();
    model_line(ln);
  endtask

  task automatic pixel(input string tag, input int hc, input bit pv, input int data, input bit men);
    int es, ex, ey;
    bit eh, ph;
    es = 0; ex = 0; ey = 0; eh = 1'b0;
    if (pv) begin
      foreach (act_e[i]) begin
        if (!eh && hc >= m_x[act_e[i]] && hc < m_x[act_e[i]] + 16) begin
          eh = 1'b1;
          es = m_sel[act_e[i]];
          ex = hc - m_x[act_e[i]];
`ifdef MOV_SPRITE_FLIP_EN
          if (m_flip[act_e[i]]) ex = 15 - ex;
`endif
          ey = act_row[i];
        end
      end
    end
    hcount = 10'(hc); pixel_valid = pv;
    tick();
    pixel_valid = 1'b0;
    check({tag, ".sel"}, 32'(spr_select), es);
    check({tag, ".x"}, 32'(spr_x), ex);
    check({tag, ".y"}, 32'(spr_y), ey);
    spr_data = 2'(data); spr_men = men;
    tick();
    ph = eh && men && (data != 0);
    check({tag, ".hit"}, 32'(pix_hit), 32'(ph));
    check({tag, ".out"}, 32'(pix_out), ph ? data : 0);
    spr_data = 2'd0; spr_men = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".pix_out"}, 32'(pix_out), 0);
    check({tag, ".pix_hit"}, 32'(pix_hit), 0);
    check({tag, ".overflow"}, 32'(overflow), 0);
    check({tag, ".spr_select"}, 32'(spr_select), 0);
    check({tag, ".spr_x"}, 32'(spr_x), 0);
    check({tag, ".spr_y"}, 32'(spr_y), 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_index = '0; wr_xpos = '0; wr_ypos = '0; wr_sel = '0;
    wr_enable = 1'b0; wr_flip = 1'b0; line_start = 1'b0; line_num = '0; hcount = '0;
    pixel_valid = 1'b0; spr_data = '0; spr_men = 1'b0;
    for (int e = 0; e < NE; e++) begin
      m_x[e] = 0; m_y[e] = 0; m_sel[e] = 0; m_en[e] = 1'b0; m_flip[e] = 1'b0;
    end
    model_line(0);
    tick(); tick();
    reset = 1'b0;
    check_all_zero("reset");

    // Single sprite, basic request and colour path.
    wr(0, 100, 50, 1, 1'b1, 1'b0);
    do_line(55);
    check("basic.overflow", 32'(overflow), 32'(m_ovf));
    pixel("basic", 103, 1'b1, 2, 1'b1);
    pixel("basic_novalid", 103, 1'b0, 2, 1'b1);
    pixel("basic_men0", 104, 1'b1, 3, 1'b0);
    pixel("basic_miss", 116, 1'b1, 1, 1'b1);

    // Five sprites on one line: slot limit and overflow.
    wr(0, 100, 10, 10, 1'b1, 1'b0);
    wr(1, 200, 15, 11, 1'b1, 1'b0);
    wr(2, 300, 20, 12, 1'b1, 1'b0);
    wr(3, 400, 8, 13, 1'b1, 1'b0);
    wr(4, 500, 12, 14, 1'b1, 1'b0);
    do_line(20);
    check("ovf.set", 32'(overflow), 1);
    check("ovf.model", 32'(m_ovf), 1);
    for (int e = 0; e < 5; e++) pixel($sformatf("ovf.e%0d", e), m_x[e] + 1, 1'b1, 1, 1'b1);
    line_start = 1'b1; line_num = 10'd900;
    tick();
    line_start = 1'b0;
    check("ovf.clear", 32'(overflow), 0);
    repeat (NE + 3) tick();
    model_line(900);

    // Overlap: a transparent front sprite hides the one behind it.
    wr(0, 0, 0, 0, 1'b0, 1'b0);
    wr(1, 190, 300, 21, 1'b1, 1'b0);
    wr(2, 0, 0, 0, 1'b0, 1'b0);
    wr(3, 195, 300, 23, 1'b1, 1'b0);
    wr(4, 0, 0, 0, 1'b0, 1'b0);
    do_line(305);
    pixel("overlap.clear", 200, 1'b1, 0, 1'b1);
    pixel("overlap.opaque", 200, 1'b1, 3, 1'b1);
    pixel("overlap.back", 208, 1'b1, 1, 1'b1);

    // Bottom edge: no wrap-around into the top lines.
    wr(2, 600, 1015, 33, 1'b1, 1'b0);
    do_line(1020);
    pixel("edge.1020", 605, 1'b1, 1, 1'b1);
    do_line(3);
    pixel("edge.3", 605, 1'b1, 1, 1'b1);

    // Reset in the middle of a scan.
    do_line(1020);
    line_start = 1'b1; line_num = 10'd1020;
    tick();
    line_start = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < NE; e++) m_en[e] = 1'b0;
    act_e.delete(); act_row.delete(); m_ovf = 1'b0;
    check_all_zero("midreset");
    repeat (NE + 3) tick();
    pixel("midreset.pix", 605, 1'b1, 3, 1'b1);

    // Horizontal mirror (expectation follows the build option).
    wr(0, 700, 0, 5, 1'b1, 1'b1);
    do_line(5);
    pixel("flip", 702, 1'b1, 2, 1'b1);

    // Randomized tables, lines and pixels.
    for (int it = 0; it < 8; it++) begin
      int ln;
      ln = int'($urandom_range(0, 1023));
      for (int e = 0; e < NE; e++) begin
        int y;
        y = ln - int'($urandom_range(0, 24));
        if (y < 0) y = y + 1024;
        wr(e, int'($urandom_range(0, 1000)), y, int'($urandom_range(0, 63)),
           ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      end
      do_line(ln);
      check($sformatf("rnd%0d.overflow", it), 32'(overflow), 32'(m_ovf));
      for (int p = 0; p < 8; p++) begin
        int hc;
        if (act_e.size() > 0 && $urandom_range(0, 3) != 0) begin
          hc = m_x[act_e[$urandom_range(0, act_e.size() - 1)]] + int'($urandom_range(0, 17));
          if (hc > 1023) hc = 1023;
        end else begin
          hc = int'($urandom_range(0, 1023));
        end
        pixel($sformatf("rnd%0d.p%0d", it, p), hc, ($urandom_range(0, 7) != 0),
              int'($urandom_range(0, 3)), ($urandom_range(0, 5) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
